// File: rtl/fetch_pc_gen_if.sv
// Fetch-PC generator to address-FIFO bundle: the redirect, pop and stall controls coming in,
// and the push strobe, address, flush and credit count going out.
interface fetch_pc_gen_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          i_redirect_valid;
    logic [31:0]   i_redirect_pc;
    logic          i_pop;
    logic          i_stall;
    logic          o_npc_valid;
    logic [31:0]   o_npc;
    logic          o_flush;
    logic [CW-1:0] o_credits;

    modport master (
        input  i_redirect_valid, i_redirect_pc, i_pop, i_stall,
        output o_npc_valid, o_npc, o_flush, o_credits
    );

    modport slave (
        output i_redirect_valid, i_redirect_pc, i_pop, i_stall,
        input  o_npc_valid, o_npc, o_flush, o_credits
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Sequential fetch-PC producer for the instruction-address FIFO: credit-based push,
// redirect flush/restart, and a parked state after a misaligned PC is issued.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PC_STEP    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fetch_pc_gen_if.master        bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_credits;
    logic          w_push;
    logic          w_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_redirect_valid) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                RUN:     if (w_push && r_pc[1:0] != 2'b00) w_state_nxt = HALT;
                FLUSH:   w_state_nxt = RUN;
                HALT:    w_state_nxt = HALT;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Both strobes are gated by reset so nothing reaches the FIFO while it is held in reset.
    always_comb begin
        w_push  = i_rst_n && (r_state == RUN) && (r_credits != '0)
                  && !bus.i_stall && !bus.i_redirect_valid;
        w_flush = i_rst_n && (r_state == FLUSH);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_credits <= FULL;
        end else begin
            if (bus.i_redirect_valid) r_pc <= bus.i_redirect_pc;
            else if (w_push)          r_pc <= r_pc + 32'(PC_STEP);

            // The flush empties the FIFO, so any pop seen during it is irrelevant.
            if (r_state == FLUSH)                       r_credits <= FULL;
            else if (w_push && !bus.i_pop)              r_credits <= r_credits - 1'b1;
            else if (!w_push && bus.i_pop && r_credits != FULL)
                                                        r_credits <= r_credits + 1'b1;
        end
    end

    assign bus.o_npc_valid = w_push;
    assign bus.o_npc       = r_pc;
    assign bus.o_flush     = w_flush;
    assign bus.o_credits   = r_credits;
endmodule
